ram_ctrl: RTL and testbench
===========================

Name: ram_ctrl

Overview:
- Arbitrates and sequences the DRAM between CPU accesses and refresh; FSB is the upstream bus block.
- Consumes FSB's AS detection and refresh request signals (ASActive, ASInactive, RefReq, RefUrgent).
- Drives RAS/CAS/WE/OE strobes and the row/column address-mux select.
- Returns RefAck and Ready to FSB, which uses Ready to generate DTACK.

Parameters:
- TRAS, 2, refresh RAS-low cycles (1..15).
- TRP, 2, precharge cycles with all strobes high (1..15).

Ports:
- FCLK  in  1  bus clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- ASActive  in  1  CPU address strobe asserted (from FSB).
- ASInactive  in  1  CPU address strobe fully released (from FSB).
- RAMCS  in  1  current bus cycle decodes to DRAM.
- RnW  in  1  CPU read(1)/write(0).
- nLDS  in  1  CPU lower data strobe.
- nUDS  in  1  CPU upper data strobe.
- RefReq  in  1  refresh owed this period.
- RefUrgent  in  1  refresh overdue; preempts CPU access.
- RefAck  out  1  one-cycle pulse: refresh started.
- Ready  out  1  DRAM data valid/latched; FSB may assert DTACK.
- nRAS  out  1  DRAM row strobe.
- nCASL  out  1  DRAM lower-byte column strobe.
- nCASH  out  1  DRAM upper-byte column strobe.
- nWE  out  1  DRAM write enable.
- nOE  out  1  DRAM output enable.
- RASEL  out  1  address mux select: 1 = row, 0 = column.

Behaviour:
- All outputs registered.
- Reset values: nRAS=1, nCASL=1, nCASH=1, nWE=1, nOE=1, RASEL=1, RefAck=0, Ready=0.
- Reset loads state PRECHG with counter=TRP, so tRP is honoured after a mid-cycle reset.
- Reset has priority over every other event.
- Default outputs in every state not listed: all strobes high, RASEL=1, Ready=0, RefAck=0.
- IDLE arbitration, priority order:
  - (1) RefUrgent -> REF_CAS.
  - (2) ASActive & RAMCS -> ACC_RAS.
  - (3) RefReq -> REF_CAS.
  - (4) otherwise stay IDLE.
- ACC_RAS (1 cycle): nRAS=0, RASEL=1. ASInactive -> PRECHG(TRP); else -> ACC_COL.
- ACC_COL (1 cycle): nRAS=0, RASEL=0.
  - nWE=RnW, so writes use early-write timing (nWE low before CAS).
  - ASInactive -> PRECHG; else -> ACC_CAS.
- ACC_CAS: nRAS=0, RASEL=0, nWE=RnW, nCASL=nLDS, nCASH=nUDS, nOE=~RnW, Ready=1.
  - Byte strobes are resampled every cycle.
  - Hold until ASInactive -> PRECHG(TRP).
  - First Ready=1 is exactly 3 posedges after the IDLE edge that accepted the access.
- REF_CAS (1 cycle, CAS-before-RAS): nCASL=nCASH=0, RefAck=1 -> REF_RAS with counter=TRAS.
- REF_RAS: nCASL=nCASH=0, nRAS=0. Counter decrements each cycle; at 1 -> PRECHG(TRP).
  - Refresh occupancy is 1+TRAS cycles plus TRP precharge.
- PRECHG: all strobes high. Counter decrements; at 1 -> IDLE. No request is accepted while counting.
- Collisions:
  - AS arriving during a refresh or precharge waits in IDLE arbitration. Ready stays 0, so the CPU inserts wait states.
  - RefReq (non-urgent) arriving during an access waits until that access reaches PRECHG and IDLE.
  - RefUrgent and access in the same IDLE cycle: refresh wins; the access follows after PRECHG.
- RefAck is a single-cycle pulse per refresh. FSB clears RefReq within the refresh occupancy (at least 3 cycles), so there is no double refresh.
- Abort: ASInactive in ACC_RAS or ACC_COL goes to PRECHG without ever asserting CAS or Ready.
- Ready is 0 in all states except ACC_CAS. When RAMCS=0 the block stays idle; other domains supply their own ready.

Test Plan:
- Read, nLDS=nUDS=0, TRP=2: after the accept edge, nRAS=0 at +1, RASEL=0 at +2, nCAS*=0/nOE=0/Ready=1 at +3. ASInactive -> all high, Ready=0 next edge. IDLE 2 cycles later.
- Upper-byte write (RnW=0, nUDS=0, nLDS=1): nWE=0 from ACC_COL, nCASH=0 only, nCASL=1, nOE=1 throughout.
- Idle refresh with RefReq=1 and AS inactive: RefAck pulses exactly 1 cycle with nCAS*=0. nRAS=0 for TRAS=2 cycles. Strobes high TRP cycles; no second RefAck.
- RefUrgent=1 and ASActive&RAMCS in the same IDLE cycle: refresh runs first. Access Ready=1 at accept+3 after returning to IDLE.
- Non-urgent RefReq raised during ACC_CAS: no RefAck until after ASInactive plus TRP precharge.
- Reset asserted in ACC_CAS: next edge all strobes high, Ready=0. No state exit before TRP cycles; pending access then served normally.

Source files
------------

// File: rtl/ram_ctrl.sv
`timescale 1ns/1ps
// ram_ctrl
// DRAM sequencer that shares the array between CPU bus cycles and
// CAS-before-RAS refresh. The upstream bus block (FSB) supplies the
// address-strobe and refresh-request signals. It receives RefAck and
// Ready back, and turns Ready into DTACK.
//
// Ports
//   FCLK        bus clock, all logic on the rising edge
//   Reset       synchronous, active-high
//   ASActive    CPU address strobe asserted
//   ASInactive  CPU address strobe fully released
//   RAMCS       current bus cycle decodes to DRAM
//   RnW         1 = read, 0 = write
//   nLDS/nUDS   CPU lower/upper data strobes (active low)
//   RefReq      refresh owed this period
//   RefUrgent   refresh overdue, wins over a CPU access
//   RefAck      one-cycle pulse when a refresh starts
//   Ready       DRAM data valid/latched
//   nRAS, nCASL, nCASH, nWE, nOE   DRAM strobes (active low)
//   RASEL       address mux select, 1 = row, 0 = column
//
// Every output is a register. Its value is the decode of the state that
// was current at the edge, combined with the inputs sampled at that edge.
// The strobes therefore trail the state register by one cycle. With this
// timing, Ready first rises three edges after IDLE accepts an access.
module ram_ctrl #(
  parameter int TRAS = 2,
  parameter int TRP  = 2
) (
  input  logic FCLK,
  input  logic Reset,
  input  logic ASActive,
  input  logic ASInactive,
  input  logic RAMCS,
  input  logic RnW,
  input  logic nLDS,
  input  logic nUDS,
  input  logic RefReq,
  input  logic RefUrgent,
  output logic RefAck,
  output logic Ready,
  output logic nRAS,
  output logic nCASL,
  output logic nCASH,
  output logic nWE,
  output logic nOE,
  output logic RASEL
);

  localparam logic [3:0] TRAS_C = 4'(TRAS);
  localparam logic [3:0] TRP_C  = 4'(TRP);

  typedef enum logic [2:0] {
    IDLE,
    ACC_RAS,
    ACC_COL,
    ACC_CAS,
    REF_CAS,
    REF_RAS,
    PRECHG
  } state_t;

  state_t     state, state_nxt;
  logic [3:0] cnt, cnt_nxt;

  logic ref_ack_nxt, ready_nxt, ras_nxt, casl_nxt, cash_nxt;
  logic we_nxt, oe_nxt, rasel_nxt;

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    ref_ack_nxt = 1'b0;
    ready_nxt   = 1'b0;
    ras_nxt     = 1'b1;
    casl_nxt    = 1'b1;
    cash_nxt    = 1'b1;
    we_nxt      = 1'b1;
    oe_nxt      = 1'b1;
    rasel_nxt   = 1'b1;

    case (state)
      IDLE: begin
        // An overdue refresh outranks the CPU, and the CPU outranks a
        // refresh that is merely owed.
        if (RefUrgent) begin
          state_nxt = REF_CAS;
        end else if (ASActive && RAMCS) begin
          state_nxt = ACC_RAS;
        end else if (RefReq) begin
          state_nxt = REF_CAS;
        end
      end

      ACC_RAS: begin
        ras_nxt = 1'b0;
        if (ASInactive) begin
          state_nxt = PRECHG;
          cnt_nxt   = TRP_C;
        end else begin
          state_nxt = ACC_COL;
        end
      end

      ACC_COL: begin
        // nWE is driven here, before CAS falls, so that writes use
        // early-write timing and the DRAM keeps its outputs off.
        ras_nxt   = 1'b0;
        rasel_nxt = 1'b0;
        we_nxt    = RnW;
        if (ASInactive) begin
          state_nxt = PRECHG;
          cnt_nxt   = TRP_C;
        end else begin
          state_nxt = ACC_CAS;
        end
      end

      ACC_CAS: begin
        // Byte strobes follow the CPU every cycle while CAS is held.
        ras_nxt   = 1'b0;
        rasel_nxt = 1'b0;
        we_nxt    = RnW;
        casl_nxt  = nLDS;
        cash_nxt  = nUDS;
        oe_nxt    = ~RnW;
        ready_nxt = 1'b1;
        if (ASInactive) begin
          state_nxt = PRECHG;
          cnt_nxt   = TRP_C;
        end
      end

      REF_CAS: begin
        casl_nxt    = 1'b0;
        cash_nxt    = 1'b0;
        ref_ack_nxt = 1'b1;
        state_nxt   = REF_RAS;
        cnt_nxt     = TRAS_C;
      end

      REF_RAS: begin
        casl_nxt = 1'b0;
        cash_nxt = 1'b0;
        ras_nxt  = 1'b0;
        if (cnt <= 4'd1) begin
          state_nxt = PRECHG;
          cnt_nxt   = TRP_C;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      PRECHG: begin
        if (cnt <= 4'd1) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end

      default: begin
        state_nxt = PRECHG;
        cnt_nxt   = TRP_C;
      end
    endcase
  end

  // ---- state and output registers ----
  // Reset lands in PRECHG rather than IDLE. A reset that cuts an access
  // short still gives the DRAM its full precharge time.
  always_ff @(posedge FCLK) begin
    if (Reset) begin
      state  <= PRECHG;
      cnt    <= TRP_C;
      RefAck <= 1'b0;
      Ready  <= 1'b0;
      nRAS   <= 1'b1;
      nCASL  <= 1'b1;
      nCASH  <= 1'b1;
      nWE    <= 1'b1;
      nOE    <= 1'b1;
      RASEL  <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      RefAck <= ref_ack_nxt;
      Ready  <= ready_nxt;
      nRAS   <= ras_nxt;
      nCASL  <= casl_nxt;
      nCASH  <= cash_nxt;
      nWE    <= we_nxt;
      nOE    <= oe_nxt;
      RASEL  <= rasel_nxt;
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
`timescale 1ns/1ps
// Testbench for ram_ctrl.
// The reference model describes the controller as an activity and the
// number of cycles that activity has lasted. The activities are idle,
// access, refresh and precharge. At each edge the model predicts the
// registered outputs and advances.
module tb_ram_ctrl;

  localparam int TRAS_T = 3;
  localparam int TRP_T  = 2;

  logic FCLK = 1'b0;
  logic Reset = 1'b1;
  logic ASActive = 1'b0, ASInactive = 1'b1, RAMCS = 1'b0, RnW = 1'b1;
  logic nLDS = 1'b1, nUDS = 1'b1, RefReq = 1'b0, RefUrgent = 1'b0;
  logic RefAck, Ready, nRAS, nCASL, nCASH, nWE, nOE, RASEL;

  int n_tests = 0;
  int n_fail  = 0;

  localparam int K_IDLE = 0, K_ACC = 1, K_REF = 2, K_PRE = 3;
  int kind = K_PRE;
  int age  = 0;
  logic e_ack, e_rdy, e_ras, e_casl, e_cash, e_we, e_oe, e_rasel;

  ram_ctrl #(.TRAS(TRAS_T), .TRP(TRP_T)) dut (
    .FCLK(FCLK), .Reset(Reset), .ASActive(ASActive), .ASInactive(ASInactive),
    .RAMCS(RAMCS), .RnW(RnW), .nLDS(nLDS), .nUDS(nUDS), .RefReq(RefReq),
    .RefUrgent(RefUrgent), .RefAck(RefAck), .Ready(Ready), .nRAS(nRAS),
    .nCASL(nCASL), .nCASH(nCASH), .nWE(nWE), .nOE(nOE), .RASEL(RASEL)
  );

  always #5 FCLK = ~FCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Predict the outputs registered at this edge from the activity in
  // force before it, then move the activity on.
  task automatic model_edge();
    e_ack = 0; e_rdy = 0; e_ras = 1; e_casl = 1; e_cash = 1;
    e_we = 1; e_oe = 1; e_rasel = 1;
    if (Reset) begin
      kind = K_PRE;
      age  = 0;
    end else begin
      case (kind)
        K_IDLE: begin
          if (RefUrgent)             begin kind = K_REF; age = 0; end
          else if (ASActive && RAMCS) begin kind = K_ACC; age = 0; end
          else if (RefReq)           begin kind = K_REF; age = 0; end
        end
        K_ACC: begin
          e_ras = 0;
          if (age >= 1) begin
            e_rasel = 0;
            e_we    = RnW;
          end
          if (age >= 2) begin
            e_casl = nLDS;
            e_cash = nUDS;
            e_oe   = ~RnW;
            e_rdy  = 1;
          end
          if (ASInactive) begin kind = K_PRE; age = 0; end
          else if (age < 2) age++;
        end
        K_REF: begin
          e_casl = 0;
          e_cash = 0;
          if (age == 0) e_ack = 1;
          else          e_ras = 0;
          if (age >= TRAS_T) begin kind = K_PRE; age = 0; end
          else age++;
        end
        default: begin
          if (age >= TRP_T - 1) begin kind = K_IDLE; age = 0; end
          else age++;
        end
      endcase
    end
  endtask

  task automatic cyc();
    @(posedge FCLK);
    model_edge();
    #1;
    chk("RefAck", 32'(RefAck), 32'(e_ack));
    chk("Ready",  32'(Ready),  32'(e_rdy));
    chk("nRAS",   32'(nRAS),   32'(e_ras));
    chk("nCASL",  32'(nCASL),  32'(e_casl));
    chk("nCASH",  32'(nCASH),  32'(e_cash));
    chk("nWE",    32'(nWE),    32'(e_we));
    chk("nOE",    32'(nOE),    32'(e_oe));
    chk("RASEL",  32'(RASEL),  32'(e_rasel));
  endtask

  // The FSB withdraws its refresh request once the refresh is acknowledged.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      if (e_ack) begin
        RefReq    = 0;
        RefUrgent = 0;
      end
    end
  endtask

  task automatic bus_start(input logic rw, input logic lds, input logic uds, input logic cs);
    ASActive = 1; ASInactive = 0; RnW = rw; nLDS = lds; nUDS = uds; RAMCS = cs;
  endtask

  task automatic bus_end();
    ASActive = 0; ASInactive = 1; nLDS = 1; nUDS = 1;
  endtask

  initial begin
    int as_len, gap;
    logic as_on;

    // Reset state, then the initial precharge.
    run(2);
    Reset = 0;
    run(4);

    // Read of both bytes.
    bus_start(1, 0, 0, 1); run(6); bus_end(); run(5);
    // Write of the upper byte only.
    bus_start(0, 1, 0, 1); run(6); bus_end(); run(5);
    // Refresh while the CPU is idle.
    RefReq = 1; run(10);
    // Urgent refresh and an access arrive in the same idle cycle.
    RefUrgent = 1; RefReq = 1; bus_start(1, 0, 0, 1); run(14); bus_end(); run(5);
    // A non-urgent refresh is requested during the CAS phase.
    bus_start(1, 0, 1, 1); run(4); RefReq = 1; run(3); bus_end(); run(12);
    // Aborts in the row and column phases.
    bus_start(1, 0, 0, 1); run(1); bus_end(); run(5);
    bus_start(0, 0, 0, 1); run(2); bus_end(); run(5);
    // An access that does not decode to DRAM.
    bus_start(1, 0, 0, 0); run(5); bus_end(); run(3);
    // Reset during CAS while the CPU keeps the strobe asserted.
    bus_start(1, 0, 0, 1); run(5); Reset = 1; run(1); Reset = 0; run(8); bus_end(); run(5);

    // Randomized traffic shaped like real bus cycles.
    as_on = 0; as_len = 0; gap = 2;
    for (int i = 0; i < 3000; i++) begin
      if (as_on) begin
        if ($urandom_range(0, 3) == 0) begin nLDS = 1'($urandom); nUDS = 1'($urandom); end
        as_len--;
        if (as_len <= 0) begin as_on = 0; bus_end(); gap = $urandom_range(0, 4); end
      end else begin
        if (gap <= 0) begin
          as_on = 1; as_len = $urandom_range(1, 9);
          bus_start(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
        end else gap--;
      end
      if (!RefReq && $urandom_range(0, 24) == 0) RefReq = 1;
      if (RefReq && !RefUrgent && $urandom_range(0, 15) == 0) RefUrgent = 1;
      Reset = ($urandom_range(0, 299) == 0);
      run(1);
    end
    Reset = 0;

    // Unconstrained input bits.
    for (int i = 0; i < 800; i++) begin
      ASActive = 1'($urandom); ASInactive = 1'($urandom); RAMCS = 1'($urandom);
      RnW = 1'($urandom); nLDS = 1'($urandom); nUDS = 1'($urandom);
      RefReq = ($urandom_range(0, 7) == 0); RefUrgent = ($urandom_range(0, 15) == 0);
      Reset = ($urandom_range(0, 99) == 0);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
